// File: rtl/branch_pc_unit_pkg.sv
// Shared definitions for the branch/PC stage.
//   PC_W        : width of every address in the stage
//   INSTR_BYTES : sequential fetch step and the BL link offset
//   PIPE_AHEAD  : the architectural PC reads as branch address + 8
//   bpu_state_t : RUN / FLUSH, exported on the interface for observation
package branch_pkg;
    localparam int PC_W        = 32;
    localparam int INSTR_BYTES = 4;
    localparam int PIPE_AHEAD  = 8;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } bpu_state_t;
endpackage

// File: rtl/branch_pc_unit_if.sv
// Bus between the execute/fetch side and branch_pc_unit.
//   master : drives branch_* and fetch_ready, observes the fetch request,
//            squash, link write and the FSM state
//   slave  : the branch_pc_unit itself
// Handshake: a fetch request is transferred on a rising edge where
// fetch_valid & fetch_ready are both 1. Only then does fetch_pc step by 4;
// while fetch_valid & !fetch_ready it is held, except for a taken-branch
// redirect, which replaces fetch_pc regardless of fetch_ready.
interface branch_pc_unit_if;
    import branch_pkg::*;

    logic            branch_valid;
    logic            branch_cond_pass;
    logic            branch_link;
    logic [PC_W-1:0] branch_pc;
    logic [PC_W-1:0] branch_offset;
    logic            fetch_ready;
    logic [PC_W-1:0] fetch_pc;
    logic            fetch_valid;
    logic            squash;
    logic            lr_we;
    logic [PC_W-1:0] lr_wdata;
    bpu_state_t      state;

    modport master (
        output branch_valid, branch_cond_pass, branch_link,
        output branch_pc, branch_offset, fetch_ready,
        input  fetch_pc, fetch_valid, squash, lr_we, lr_wdata, state
    );

    modport slave (
        input  branch_valid, branch_cond_pass, branch_link,
        input  branch_pc, branch_offset, fetch_ready,
        output fetch_pc, fetch_valid, squash, lr_we, lr_wdata, state
    );
endinterface

// File: rtl/branch_pc_unit_target.sv
// Combinational branch target: branch_pc + 8 + offset (mod 2^32), with the
// two low bits cleared so the redirect is always word aligned.
//   branch_pc     in  : address of the branch instruction
//   branch_offset in  : sign-extended, word-scaled offset
//   target        out : aligned redirect address
module branch_target_adder
    import branch_pkg::*;
(
    input  logic [PC_W-1:0] branch_pc,
    input  logic [PC_W-1:0] branch_offset,
    output logic [PC_W-1:0] target
);
    localparam logic [PC_W-1:0] ALIGN_MASK = ~(PC_W'(INSTR_BYTES) - PC_W'(1));

    assign target = (branch_pc + PC_W'(PIPE_AHEAD) + branch_offset) & ALIGN_MASK;
endmodule

// File: rtl/branch_pc_unit.sv
// Fetch PC register and taken-branch redirect.
//   clk, rst : single clock, synchronous active-high reset
//   bus      : slave side of branch_pc_unit_if (branch inputs, fetch
//              handshake, squash, link write, FSM state)
// Parameters: RESET_PC (fetch address after reset), FLUSH_SLOTS (>= 1,
// number of cycles squash stays high after a redirect).
module branch_pc_unit
    import branch_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          FLUSH_SLOTS = 2
) (
    input  logic              clk,
    input  logic              rst,
    branch_pc_unit_if.slave   bus
);
    localparam logic [0:0] ST_RUN   = 1'b0;
    localparam logic [0:0] ST_FLUSH = 1'b1;
    localparam int         CNT_W    = $clog2(FLUSH_SLOTS + 1);

    logic [0:0]      state_q;
    logic [CNT_W-1:0] flush_cnt_q;
    logic [PC_W-1:0] fetch_pc_q;
    logic            fetch_valid_q;
    logic            squash_q;
    logic            lr_we_q;
    logic [PC_W-1:0] lr_wdata_q;
    logic [PC_W-1:0] target;
    logic            taken;

    branch_target_adder u_target (
        .branch_pc     (bus.branch_pc),
        .branch_offset (bus.branch_offset),
        .target        (target)
    );

    // Branches arriving while flushing are themselves wrong-path.
    assign taken = bus.branch_valid & bus.branch_cond_pass & (state_q == ST_RUN);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_RUN;
            flush_cnt_q   <= '0;
            fetch_pc_q    <= RESET_PC;
            fetch_valid_q <= 1'b0;
            squash_q      <= 1'b0;
            lr_we_q       <= 1'b0;
            lr_wdata_q    <= '0;
        end else begin
            fetch_valid_q <= 1'b1;
            lr_we_q       <= 1'b0;
            if (taken) begin
                fetch_pc_q  <= target;
                state_q     <= ST_FLUSH;
                flush_cnt_q <= CNT_W'(FLUSH_SLOTS);
                squash_q    <= 1'b1;
                if (bus.branch_link) begin
                    lr_we_q    <= 1'b1;
                    lr_wdata_q <= bus.branch_pc + PC_W'(INSTR_BYTES);
                end
            end else begin
                if (fetch_valid_q && bus.fetch_ready) begin
                    fetch_pc_q <= fetch_pc_q + PC_W'(INSTR_BYTES);
                end
                if (state_q == ST_FLUSH) begin
                    flush_cnt_q <= flush_cnt_q - CNT_W'(1);
                    // Counter about to hit zero: this edge ends the squash window.
                    if (flush_cnt_q == CNT_W'(1)) begin
                        squash_q <= 1'b0;
                        state_q  <= ST_RUN;
                    end
                end
            end
        end
    end

    assign bus.fetch_pc    = fetch_pc_q;
    assign bus.fetch_valid = fetch_valid_q;
    assign bus.squash      = squash_q;
    assign bus.lr_we       = lr_we_q;
    assign bus.lr_wdata    = lr_wdata_q;
    assign bus.state       = bpu_state_t'(state_q);
endmodule

// File: tb/tb_branch_pc_unit.sv
// Directed bench for branch_pc_unit with RESET_PC = 0x100, FLUSH_SLOTS = 2.
// Each record holds the inputs driven for one cycle and the outputs expected
// after the following rising edge.
module tb_branch_pc_unit;
    import branch_pkg::*;

    typedef struct {
        logic        rst;
        logic        bv;
        logic        cp;
        logic        bl;
        logic [31:0] bpc;
        logic [31:0] boff;
        logic        fr;
        logic [31:0] e_pc;
        logic        e_fv;
        logic        e_sq;
        logic        e_we;
        logic [31:0] e_wd;
        logic        e_st;
    } vec_t;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    branch_pc_unit_if bus ();

    branch_pc_unit #(
        .RESET_PC    (32'h0000_0100),
        .FLUSH_SLOTS (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- scoreboard ----------------
    vec_t vq[$];
    int   n_vec  = 0;
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic add(input logic r, input logic bv, input logic cp, input logic bl,
                       input logic [31:0] bpc, input logic [31:0] boff, input logic fr,
                       input logic [31:0] e_pc, input logic e_fv, input logic e_sq,
                       input logic e_we, input logic [31:0] e_wd, input logic e_st);
        vec_t v;
        v.rst = r;  v.bv = bv; v.cp = cp; v.bl = bl;
        v.bpc = bpc; v.boff = boff; v.fr = fr;
        v.e_pc = e_pc; v.e_fv = e_fv; v.e_sq = e_sq;
        v.e_we = e_we; v.e_wd = e_wd; v.e_st = e_st;
        vq.push_back(v);
    endtask

    task automatic chk(input int idx, input string name,
                       input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL vec %0d %s: got %h expected %h", idx, name, act, exp);
        end
    endtask

    // ---------------- driver ----------------
    task automatic apply_vec(input int idx, input vec_t v);
        rst                  = v.rst;
        bus.branch_valid     = v.bv;
        bus.branch_cond_pass = v.cp;
        bus.branch_link      = v.bl;
        bus.branch_pc        = v.bpc;
        bus.branch_offset    = v.boff;
        bus.fetch_ready      = v.fr;
        @(posedge clk);
        #1;
        n_vec++;
        chk(idx, "fetch_pc",    bus.fetch_pc,          v.e_pc);
        chk(idx, "fetch_valid", {31'b0, bus.fetch_valid}, {31'b0, v.e_fv});
        chk(idx, "squash",      {31'b0, bus.squash},   {31'b0, v.e_sq});
        chk(idx, "lr_we",       {31'b0, bus.lr_we},    {31'b0, v.e_we});
        chk(idx, "lr_wdata",    bus.lr_wdata,          v.e_wd);
        chk(idx, "state",       {31'b0, bus.state},    {31'b0, v.e_st});
    endtask

    initial begin
        vec_t h;
        rst                  = 1'b1;
        bus.branch_valid     = 1'b0;
        bus.branch_cond_pass = 1'b0;
        bus.branch_link      = 1'b0;
        bus.branch_pc        = '0;
        bus.branch_offset    = '0;
        bus.fetch_ready      = 1'b0;

        //   rst bv cp bl bpc           boff          fr  e_pc          fv sq we e_wd          st
        // reset held two cycles
        add(1, 0, 0, 0, 32'h0,        32'h0,        0, 32'h100,       0, 0, 0, 32'h0,       0);
        add(1, 0, 0, 0, 32'h0,        32'h0,        1, 32'h100,       0, 0, 0, 32'h0,       0);
        // first edge out of reset: valid rises, no step yet
        add(0, 0, 0, 0, 32'h0,        32'h0,        1, 32'h100,       1, 0, 0, 32'h0,       0);
        // fetch_ready 1,0,1,1
        add(0, 0, 0, 0, 32'h0,        32'h0,        1, 32'h104,       1, 0, 0, 32'h0,       0);
        add(0, 0, 0, 0, 32'h0,        32'h0,        0, 32'h104,       1, 0, 0, 32'h0,       0);
        add(0, 0, 0, 0, 32'h0,        32'h0,        1, 32'h108,       1, 0, 0, 32'h0,       0);
        add(0, 0, 0, 0, 32'h0,        32'h0,        1, 32'h10C,       1, 0, 0, 32'h0,       0);
        // forward branch 0x200 + 8 + 0x10; branch inside FLUSH ignored
        add(0, 1, 1, 0, 32'h200,      32'h10,       1, 32'h218,       1, 1, 0, 32'h0,       1);
        add(0, 0, 0, 0, 32'h0,        32'h0,        1, 32'h21C,       1, 1, 0, 32'h0,       1);
        add(0, 1, 1, 1, 32'h500,      32'h0,        1, 32'h220,       1, 0, 0, 32'h0,       0);
        add(0, 0, 0, 0, 32'h0,        32'h0,        0, 32'h220,       1, 0, 0, 32'h0,       0);
        // backward branch with fetch_ready low: redirect still happens
        add(0, 1, 1, 0, 32'h200,      32'hFFFF_FFF8, 0, 32'h200,      1, 1, 0, 32'h0,       1);
        add(0, 0, 0, 0, 32'h0,        32'h0,        0, 32'h200,       1, 1, 0, 32'h0,       1);
        add(0, 0, 0, 0, 32'h0,        32'h0,        0, 32'h200,       1, 0, 0, 32'h0,       0);
        // BL from 0x300
        add(0, 1, 1, 1, 32'h300,      32'h0,        1, 32'h308,       1, 1, 1, 32'h304,     1);
        add(0, 0, 0, 0, 32'h0,        32'h0,        1, 32'h30C,       1, 1, 0, 32'h304,     1);
        add(0, 0, 0, 0, 32'h0,        32'h0,        1, 32'h310,       1, 0, 0, 32'h304,     0);
        // condition failed BL: nothing but the sequential step
        add(0, 1, 0, 1, 32'h400,      32'h40,       1, 32'h314,       1, 0, 0, 32'h304,     0);
        // target wraps past 2^32
        add(0, 1, 1, 0, 32'hFFFF_FFF8, 32'h0,       1, 32'h0,         1, 1, 0, 32'h304,     1);
        add(0, 0, 0, 0, 32'h0,        32'h0,        1, 32'h4,         1, 1, 0, 32'h304,     1);
        add(0, 0, 0, 0, 32'h0,        32'h0,        1, 32'h8,         1, 0, 0, 32'h304,     0);
        // misaligned branch_pc: low bits of target forced to zero
        add(0, 1, 1, 0, 32'h203,      32'h10,       0, 32'h218,       1, 1, 0, 32'h304,     1);
        add(0, 0, 0, 0, 32'h0,        32'h0,        0, 32'h218,       1, 1, 0, 32'h304,     1);
        add(0, 0, 0, 0, 32'h0,        32'h0,        0, 32'h218,       1, 0, 0, 32'h304,     0);
        // sequential step wraps 0xFFFF_FFFC -> 0
        add(0, 1, 1, 0, 32'hFFFF_FFF0, 32'h4,       1, 32'hFFFF_FFFC, 1, 1, 0, 32'h304,     1);
        add(0, 0, 0, 0, 32'h0,        32'h0,        1, 32'h0,         1, 1, 0, 32'h304,     1);
        add(0, 0, 0, 0, 32'h0,        32'h0,        0, 32'h0,         1, 0, 0, 32'h304,     0);

        for (int i = 0; i < vq.size(); i++) begin
            apply_vec(i, vq[i]);
        end

        // Hand sequence: reset in the second FLUSH cycle, then a branch right
        // after reset must be taken (state back in RUN, counter cleared).
        vq.delete();
        add(0, 1, 1, 1, 32'h600,      32'h0,        1, 32'h608,       1, 1, 1, 32'h604,     1);
        add(0, 0, 0, 0, 32'h0,        32'h0,        1, 32'h60C,       1, 1, 0, 32'h604,     1);
        add(1, 1, 1, 1, 32'h800,      32'h0,        1, 32'h100,       0, 0, 0, 32'h0,       0);
        add(0, 1, 1, 0, 32'h700,      32'h0,        1, 32'h708,       1, 1, 0, 32'h0,       1);
        add(0, 0, 0, 0, 32'h0,        32'h0,        0, 32'h708,       1, 1, 0, 32'h0,       1);
        add(0, 0, 0, 0, 32'h0,        32'h0,        0, 32'h708,       1, 0, 0, 32'h0,       0);
        for (int i = 0; i < vq.size(); i++) begin
            h = vq[i];
            apply_vec(100 + i, h);
        end

        // ---------------- report ----------------
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
